// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency and backpressure: none (declarations only).
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Access size lives in Funct3[1:0]; Funct3[2] selects zero extension on loads.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [2:0] F3_ILL = 3'b111;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_ILLEGAL  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store-data shift, load shift and extension.
// Latency: purely combinational; no backpressure.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int BITS = 64
) (
  input  logic [2:0]        funct3,
  input  logic [2:0]        offset,
  input  logic [BITS-1:0]   wdata,
  input  logic [BITS-1:0]   rdata,
  output logic [BITS/8-1:0] be,
  output logic [BITS-1:0]   wdata_sh,
  output logic [BITS-1:0]   load_data
);

  logic [BITS-1:0] rdata_sh;
  logic            zext;

  always_comb begin
    be       = (BITS/8)'(size_mask(funct3[1:0])) << offset;
    wdata_sh = wdata << {offset, 3'b000};
    rdata_sh = rdata >> {offset, 3'b000};
    zext     = funct3[2];
    case (funct3[1:0])
      SZ_B:    load_data = {{(BITS-8){rdata_sh[7] & ~zext}}, rdata_sh[7:0]};
      SZ_H:    load_data = {{(BITS-16){rdata_sh[15] & ~zext}}, rdata_sh[15:0]};
      SZ_W:    load_data = {{(BITS-32){rdata_sh[31] & ~zext}}, rdata_sh[31:0]};
      default: load_data = rdata_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One load or store per instruction on a ready-handshake memory bus, with alignment, faults and timeout.
// Latency: issue cycle + BUSY until mem_ready (or TIMEOUT), retire in DONE; Stall holds the core meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int BITS    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [BITS-1:0]   Addr,
  input  logic [BITS-1:0]   WriteData,
  output logic [BITS-1:0]   ReadData,
  output logic              Stall,
  output logic              Fault,
  output logic [1:0]        FaultCode,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BITS-1:0]   mem_addr,
  output logic [BITS/8-1:0] mem_be,
  output logic [BITS-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic [BITS-1:0]   mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [2:0]      f3_q;
  logic [2:0]      off_q;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_flag;

  logic            op_vld;
  logic            is_illegal;
  logic            is_misal;
  logic            issue;
  logic            req_fault;

  logic [2:0]        al_f3;
  logic [2:0]        al_off;
  logic [BITS/8-1:0] al_be;
  logic [BITS-1:0]   al_wdata;
  logic [BITS-1:0]   al_load;

  // The aligner sees the live request in IDLE and the latched one while BUSY.
  assign al_f3  = (state == BUSY) ? f3_q  : Funct3;
  assign al_off = (state == BUSY) ? off_q : Addr[2:0];

  lsu_align #(.BITS(BITS)) u_align (
    .funct3    (al_f3),
    .offset    (al_off),
    .wdata     (WriteData),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_sh  (al_wdata),
    .load_data (al_load)
  );

  always_comb begin
    op_vld     = MemRead | MemWrite;
    is_illegal = (Funct3 == F3_ILL) || (MemWrite && Funct3[2]);
    is_misal   = (Addr[2:0] & align_mask(Funct3[1:0])) != 3'b000;
    issue      = (state == IDLE) && op_vld && !is_illegal && !is_misal;
    req_fault  = (state == IDLE) && op_vld && (is_illegal || is_misal);

    Stall     = 1'b0;
    Fault     = 1'b0;
    FaultCode = FC_NONE;
    if (!rst) begin
      Stall = issue || (state == BUSY);
      if (req_fault) begin
        Fault     = 1'b1;
        FaultCode = is_illegal ? FC_ILLEGAL : FC_MISALIGN;
      end else if ((state == DONE) && tmo_flag) begin
        Fault     = 1'b1;
        FaultCode = FC_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      tmo_cnt   <= '0;
      tmo_flag  <= 1'b0;
      ReadData  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {Addr[BITS-1:3], 3'b000};
            mem_be    <= al_be;
            mem_wdata <= al_wdata;
            f3_q      <= Funct3;
            off_q     <= Addr[2:0];
            tmo_cnt   <= '0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_we) ReadData <= al_load;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            ReadData <= '0;
            tmo_flag <= 1'b1;
            mem_req  <= 1'b0;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          tmo_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [63:0] Addr, WriteData, ReadData;
  logic        Stall, Fault;
  logic [1:0]  FaultCode;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_rd;

  always #5 clk = ~clk;

  load_store_unit #(.BITS(64), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .Fault(Fault), .FaultCode(FaultCode), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Reference: pick the addressed bytes, then extend according to signedness.
  function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] rdata);
    int nbits;
    logic [63:0] v, m;
    nbits = 8 * (1 << f3[1:0]);
    v = rdata >> (8 * off);
    if (nbits < 64) begin
      m = (64'd1 << nbits) - 64'd1;
      v = v & m;
      if (!f3[2] && v[nbits-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [7:0] model_be(input logic [2:0] f3, input int off);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return 8'(((1 << nbytes) - 1) << off);
  endfunction

  function automatic logic [63:0] lane_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // Drives one legal op and follows it to DONE; captures what the bus and core saw.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int ready_at,
                         output int stall_cnt, output int req_cnt,
                         output logic [63:0] o_addr, output logic [7:0] o_be,
                         output logic o_we, output logic [63:0] o_wdata,
                         output logic [63:0] o_rd, output logic o_fault,
                         output logic [1:0] o_fc, output logic o_req_done);
    bit fin;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = addr; WriteData = wdata; mem_ready = 1'b0;
    #1;
    stall_cnt = int'(Stall);
    req_cnt = 0; fin = 0;
    o_addr = '0; o_be = '0; o_we = 1'b0; o_wdata = '0;
    o_rd = '0; o_fault = 1'b0; o_fc = 2'b00; o_req_done = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      Addr = {$urandom, $urandom}; WriteData = {$urandom, $urandom};
      mem_ready = (c == ready_at);
      mem_rdata = (c == ready_at) ? rdata : {$urandom, $urandom};
      #1;
      if (!Stall) begin
        o_rd = ReadData; o_fault = Fault; o_fc = FaultCode; o_req_done = mem_req;
        fin = 1;
      end else begin
        stall_cnt++;
        if (mem_req) req_cnt++;
        if (c == 0) begin
          o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
        end
      end
    end
    mem_ready = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL txn_done: Stall still %0b after 400 cycles, required 0", Stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b011; Addr = 64'h1000;
    WriteData = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (Stall !== 1'b0 || Fault !== 1'b0 || FaultCode !== 2'b00) begin
      errors++; $display("FAIL reset_ctl: Stall=%0b Fault=%0b FaultCode=%0b, required 0 0 00", Stall, Fault, FaultCode);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 8'h00) begin
      errors++; $display("FAIL reset_bus: req=%0b we=%0b be=%h, required 0 0 00", mem_req, mem_we, mem_be);
    end
    checks++;
    if (ReadData !== 64'h0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      errors++; $display("FAIL reset_data: ReadData=%h mem_addr=%h mem_wdata=%h, required 0", ReadData, mem_addr, mem_wdata);
    end
    MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = '0;
  endtask

  task automatic test_ld_basic();
    int sc, rc; logic [63:0] a, wd, rd; logic [7:0] be; logic we, f, rq; logic [1:0] fc;
    run_txn(1, 0, 3'b011, 64'h1000, 64'h0, 64'h1122334455667788, 0, sc, rc, a, be, we, wd, rd, f, fc, rq);
    checks++;
    if (a !== 64'h1000 || be !== 8'hFF || we !== 1'b0) begin
      errors++; $display("FAIL ld_bus: addr=%h be=%h we=%0b, required 1000 ff 0", a, be, we);
    end
    checks++;
    if (rd !== 64'h1122334455667788) begin
      errors++; $display("FAIL ld_data: got %h, required 1122334455667788", rd);
    end
    checks++;
    if (sc !== 2 || rc !== 1) begin
      errors++; $display("FAIL ld_stall: stall=%0d req=%0d cycles, required 2 1", sc, rc);
    end
    checks++;
    if (f !== 1'b0 || rq !== 1'b0) begin
      errors++; $display("FAIL ld_done: Fault=%0b mem_req=%0b in DONE, required 0 0", f, rq);
    end
    exp_rd = 64'h1122334455667788;
  endtask

  task automatic test_lb_lbu();
    int sc, rc; logic [63:0] a, wd, rd; logic [7:0] be; logic we, f, rq; logic [1:0] fc;
    run_txn(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000000080000000, 1, sc, rc, a, be, we, wd, rd, f, fc, rq);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFF80 || be !== 8'h08 || sc !== 3) begin
      errors++; $display("FAIL lb: data=%h be=%h stall=%0d, required ffffffffffffff80 08 3", rd, be, sc);
    end
    run_txn(1, 0, 3'b100, 64'h1003, 64'h0, 64'h0000000080000000, 0, sc, rc, a, be, we, wd, rd, f, fc, rq);
    checks++;
    if (rd !== 64'h0000000000000080) begin
      errors++; $display("FAIL lbu: data=%h, required 0000000000000080", rd);
    end
    exp_rd = 64'h80;
  endtask

  task automatic test_sh();
    int sc, rc; logic [63:0] a, wd, rd; logic [7:0] be; logic we, f, rq; logic [1:0] fc;
    run_txn(0, 1, 3'b001, 64'h2006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 0, sc, rc, a, be, we, wd, rd, f, fc, rq);
    checks++;
    if (we !== 1'b1 || be !== 8'hC0 || a !== 64'h2000) begin
      errors++; $display("FAIL sh_bus: we=%0b be=%h addr=%h, required 1 c0 2000", we, be, a);
    end
    checks++;
    if (wd[63:48] !== 16'hABCD) begin
      errors++; $display("FAIL sh_wdata: got %h, required abcd", wd[63:48]);
    end
    checks++;
    if (rd !== exp_rd) begin
      errors++; $display("FAIL sh_readdata: store changed ReadData to %h, required %h", rd, exp_rd);
    end
  endtask

  task automatic test_faults();
    logic [2:0]  f3s [4] = '{3'b010, 3'b111, 3'b111, 3'b100};
    logic [63:0] ads [4] = '{64'h3002, 64'h3000, 64'h3001, 64'h3000};
    logic        wrs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  fcs [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MemRead = ~wrs[i]; MemWrite = wrs[i]; Funct3 = f3s[i]; Addr = ads[i];
      #1;
      checks++;
      if (Fault !== 1'b1 || FaultCode !== fcs[i] || Stall !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL fault_%0d: Fault=%0b code=%0b Stall=%0b req=%0b, required 1 %0b 0 0",
                           i, Fault, FaultCode, Stall, mem_req, fcs[i]);
      end
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || Fault !== 1'b0) begin
        errors++; $display("FAIL fault_after_%0d: req=%0b Fault=%0b, required 0 0", i, mem_req, Fault);
      end
    end
  endtask

  task automatic test_timeout();
    int sc, rc; logic [63:0] a, wd, rd; logic [7:0] be; logic we, f, rq; logic [1:0] fc;
    run_txn(1, 0, 3'b011, 64'h4000, 64'h0, 64'h0, -1, sc, rc, a, be, we, wd, rd, f, fc, rq);
    checks++;
    if (rc !== 255 || sc !== 256) begin
      errors++; $display("FAIL timeout_len: req=%0d stall=%0d cycles, required 255 256", rc, sc);
    end
    checks++;
    if (f !== 1'b1 || fc !== 2'b11 || rd !== 64'h0 || rq !== 1'b0) begin
      errors++; $display("FAIL timeout_done: Fault=%0b code=%0b data=%h req=%0b, required 1 11 0 0", f, fc, rd, rq);
    end
    @(negedge clk);
    #1;
    checks++;
    if (Fault !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: Fault=%0b Stall=%0b after DONE, required 0 0", Fault, Stall);
    end
    exp_rd = '0;
  endtask

  task automatic test_random();
    int sc, rc, off, ra, nbytes;
    logic [63:0] a, wd, rd, addr, wdata, rdata, m;
    logic [7:0] be, ebe; logic we, f, rq, rdop, wrop, ill, mis; logic [1:0] fc, efc; logic [2:0] f3;
    for (int n = 0; n < 60; n++) begin
      rdop = 1'($urandom_range(0, 1)); wrop = 1'($urandom_range(0, 1));
      if (!rdop && !wrop) rdop = 1'b1;
      f3 = 3'($urandom_range(0, 7));
      nbytes = 1 << f3[1:0];
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nbytes - 1);
      off = int'(addr % 8);
      ill = (f3 == 3'b111) || (wrop && f3 >= 3'b100);
      mis = (off % nbytes) != 0;
      if (ill || mis) begin
        efc = ill ? 2'b10 : 2'b01;
        @(negedge clk);
        MemRead = rdop; MemWrite = wrop; Funct3 = f3; Addr = addr;
        #1;
        checks++;
        if (Fault !== 1'b1 || FaultCode !== efc || Stall !== 1'b0 || mem_req !== 1'b0) begin
          errors++; $display("FAIL rnd_fault_%0d: Fault=%0b code=%0b Stall=%0b req=%0b, required 1 %0b 0 0",
                             n, Fault, FaultCode, Stall, mem_req, efc);
        end
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
      end else begin
        ra = $urandom_range(0, 3);
        wdata = {$urandom, $urandom}; rdata = {$urandom, $urandom};
        run_txn(rdop, wrop, f3, addr, wdata, rdata, ra, sc, rc, a, be, we, wd, rd, f, fc, rq);
        ebe = model_be(f3, off);
        if (!wrop) exp_rd = model_load(f3, off, rdata);
        checks++;
        if (a !== {addr[63:3], 3'b000} || be !== ebe || we !== wrop) begin
          errors++; $display("FAIL rnd_bus_%0d: addr=%h be=%h we=%0b, required %h %h %0b",
                             n, a, be, we, {addr[63:3], 3'b000}, ebe, wrop);
        end
        checks++;
        if (sc !== ra + 2 || f !== 1'b0) begin
          errors++; $display("FAIL rnd_stall_%0d: stall=%0d Fault=%0b, required %0d 0", n, sc, f, ra + 2);
        end
        checks++;
        if (rd !== exp_rd) begin
          errors++; $display("FAIL rnd_rdata_%0d: got %h, required %h", n, rd, exp_rd);
        end
        if (wrop) begin
          m = lane_mask(ebe);
          checks++;
          if ((wd & m) !== ((wdata << (8 * off)) & m)) begin
            errors++; $display("FAIL rnd_wdata_%0d: got %h, required %h in lanes %h",
                               n, wd & m, (wdata << (8 * off)) & m, ebe);
          end
        end
      end
    end
  endtask

  task automatic test_reset_busy();
    int sc, rc; logic [63:0] a, wd, rd; logic [7:0] be; logic we, f, rq; logic [1:0] fc;
    run_txn(1, 0, 3'b011, 64'h5000, 64'h0, 64'hDEADBEEF_CAFEF00D, 0, sc, rc, a, be, we, wd, rd, f, fc, rq);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b011; Addr = 64'h6008; WriteData = 64'h1234;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rstbusy_pre: mem_req=%0b, required 1", mem_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || Stall !== 1'b0 || mem_we !== 1'b0 || mem_be !== 8'h00) begin
      errors++; $display("FAIL rstbusy_ctl: req=%0b Stall=%0b we=%0b be=%h, required 0 0 0 00", mem_req, Stall, mem_we, mem_be);
    end
    checks++;
    if (ReadData !== 64'h0 || mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      errors++; $display("FAIL rstbusy_data: ReadData=%h addr=%h wdata=%h, required 0", ReadData, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    run_txn(1, 0, 3'b110, 64'h7004, 64'h0, 64'h89ABCDEF_00000000, 0, sc, rc, a, be, we, wd, rd, f, fc, rq);
    checks++;
    if (rd !== 64'h0000000089ABCDEF || be !== 8'hF0 || sc !== 2) begin
      errors++; $display("FAIL rstbusy_after: data=%h be=%h stall=%0d, required 0000000089abcdef f0 2", rd, be, sc);
    end
  endtask

  initial begin
    test_reset();
    test_ld_basic();
    test_lb_lbu();
    test_sh();
    test_faults();
    test_timeout();
    test_random();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
